// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame width, responder FSM states and mode-0 constants
// common to the SPI master and slave blocks.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;
    localparam int SPI_CNT_W  = $clog2(SPI_BYTE_W);
    localparam logic [SPI_CNT_W-1:0] SPI_LAST_BIT = SPI_CNT_W'(SPI_BYTE_W - 1);

    // Mode 0: sck idles low, data captured on the rising edge.
    localparam logic SPI_CPOL = 1'b0;

    typedef enum logic {
        IDLE,
        SHIFT
    } spi_state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchronizer for one asynchronous pin with registered one-cycle
// rise/fall strobes taken from the last two synchronized samples.
module spi_edge_sync
    import spi_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_LVL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   last_p1;

    // Reset to the pin's idle level so leaving reset never fabricates an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= {SYNC_STAGES{IDLE_LVL}};
            last_p1 <= IDLE_LVL;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
            last_p1 <= sync_p0[SYNC_STAGES-1];
            rise    <= sync_p0[SYNC_STAGES-1] & ~last_p1;
            fall    <= ~sync_p0[SYNC_STAGES-1] & last_p1;
        end
    end

endmodule

// File: rtl/spi_slave_byte.sv
// Mode-0 byte-oriented SPI responder: oversampled pins, full-duplex 8-bit frames,
// one-entry transmit holding register and one-cycle receive strobe.
module spi_slave_byte
    import spi_pkg::*;
#(
    parameter int                    SYNC_STAGES = 2,
    parameter logic [SPI_BYTE_W-1:0] IDLE_TX     = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ss_n,
    input  logic                  sck,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);

    logic                   sck_rise, sck_fall, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_p0;
    logic                   mosi_sync;

    spi_state_t             state, state_nxt;
    logic [SPI_CNT_W-1:0]   bit_cnt;
    logic [SPI_BYTE_W-1:0]  shift_in, shift_out, hold_data;
    logic                   hold_full, hold_wr;
    logic                   start, stop, rise_act, fall_act, reload, byte_done;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LVL(SPI_CPOL)) u_sck_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_ss_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ss_n),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    always_ff @(posedge clk) begin
        mosi_sync_p0 <= {mosi_sync_p0[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_sync = mosi_sync_p0[SYNC_STAGES-1];

    // Deselect has priority: an sck edge arriving with ss_n rise is dropped.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        stop      = 1'b0;
        rise_act  = 1'b0;
        fall_act  = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_nxt = SHIFT;
                    start     = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_nxt = IDLE;
                    stop      = 1'b1;
                end else begin
                    rise_act = sck_rise;
                    fall_act = sck_fall;
                end
            end
        endcase
    end

    assign reload    = start | (fall_act & (bit_cnt == '0));
    assign byte_done = rise_act & (bit_cnt == SPI_LAST_BIT);
    assign hold_wr   = tx_valid & ~hold_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            hold_full   <= 1'b0;
            shift_out   <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            state       <= state_nxt;
            rx_valid    <= byte_done;
            tx_underrun <= reload & ~hold_full;

            // A write landing on an empty-register reload serves the following byte.
            if (hold_wr)
                hold_full <= 1'b1;
            else if (reload)
                hold_full <= 1'b0;

            if (start | stop)
                bit_cnt <= '0;
            else if (rise_act)
                bit_cnt <= bit_cnt + 1'b1;

            if (reload)
                shift_out <= hold_full ? hold_data : IDLE_TX;
            else if (stop)
                shift_out <= '0;
            else if (fall_act)
                shift_out <= {shift_out[SPI_BYTE_W-2:0], 1'b0};

            if (byte_done)
                rx_data <= {shift_in[SPI_BYTE_W-2:0], mosi_sync};
        end
    end

    always_ff @(posedge clk) begin
        if (hold_wr)
            hold_data <= tx_data;
        if (rise_act)
            shift_in <= {shift_in[SPI_BYTE_W-2:0], mosi_sync};
    end

    assign tx_ready = ~hold_full;
    assign busy     = (state == SHIFT);
    assign miso_oe  = busy;
    assign miso     = busy & shift_out[SPI_BYTE_W-1];

endmodule

// File: tb/tb_spi_slave_byte.sv
// Bench for spi_slave_byte: bit-banged mode-0 master plus a queue model of the
// transmit holding register and the reply/receive byte streams.
module tb_spi_slave_byte;

    localparam int         SYNC      = 2;
    localparam logic [7:0] IDLE_BYTE = 8'hFF;
    localparam int         PH        = 8;

    logic       clk = 1'b0;
    logic       rst, ss_n, sck, mosi, miso, miso_oe;
    logic       tx_valid, tx_ready, rx_valid, tx_underrun, busy;
    logic [7:0] tx_data, rx_data;

    int vectors     = 0;
    int miscompares = 0;
    int rxv_total   = 0;
    int urun_total  = 0;
    int exp_urun    = 0;
    int rx_before;

    logic [7:0] hold_q[$];
    logic [7:0] mo_bytes[8];
    logic       mid_valid[8];
    logic [7:0] mid_data[8];
    logic [7:0] scratch;

    always #5 clk = ~clk;

    spi_slave_byte #(.SYNC_STAGES(SYNC), .IDLE_TX(IDLE_BYTE)) dut (
        .clk         (clk),
        .rst         (rst),
        .ss_n        (ss_n),
        .sck         (sck),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    always @(negedge clk) begin
        if (rx_valid)    rxv_total  <= rxv_total + 1;
        if (tx_underrun) urun_total <= urun_total + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One write attempt; the model accepts it only when its register is empty.
    task automatic tx_push(input logic [7:0] d);
        logic exp_ready;
        @(negedge clk);
        exp_ready = (hold_q.size() == 0);
        chk("tx_ready", 32'(tx_ready), 32'(exp_ready));
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        if (exp_ready) hold_q.push_back(d);
    endtask

    task automatic clear_plan();
        for (int k = 0; k < 8; k++) begin
            mid_valid[k] = 1'b0;
            mid_data[k]  = 8'h00;
        end
    endtask

    // Master drives nbits bits; ss_n is released together with the final sck fall.
    task automatic frame(input int nbits);
        logic [7:0] exp_reply, got;
        int k, b;
        exp_reply = 8'h00;
        got       = 8'h00;
        @(negedge clk);
        ss_n = 1'b0;
        repeat (PH) @(negedge clk);
        chk("busy_sel", 32'(busy), 32'd1);
        chk("miso_oe_sel", 32'(miso_oe), 32'd1);
        for (int i = 0; i < nbits; i++) begin
            k = i / 8;
            b = i % 8;
            if (b == 0) begin
                if (hold_q.size() > 0) exp_reply = hold_q.pop_front();
                else begin
                    exp_reply = IDLE_BYTE;
                    exp_urun++;
                end
                got = 8'h00;
            end
            @(negedge clk);
            mosi = mo_bytes[k][7-b];
            if (b == 3 && k + 1 < 8 && (k + 1) * 8 < nbits && mid_valid[k+1])
                tx_push(mid_data[k+1]);
            repeat (PH) @(negedge clk);
            got = {got[6:0], miso};
            sck = 1'b1;
            for (int c = 1; c <= PH; c++) begin
                @(posedge clk);
                #1;
                if (b == 7 && c >= SYNC + 1 && c <= SYNC + 3)
                    chk("rx_valid_pulse", 32'(rx_valid), 32'(c == SYNC + 2));
                if (b == 7 && c == SYNC + 2)
                    chk("rx_data", 32'(rx_data), 32'(mo_bytes[k]));
            end
            @(negedge clk);
            sck = 1'b0;
            if (i == nbits - 1) ss_n = 1'b1;
            if (b == 7) chk("miso_byte", 32'(got), 32'(exp_reply));
        end
        repeat (PH) @(negedge clk);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("miso_oe_idle", 32'(miso_oe), 32'd0);
        chk("miso_idle", 32'(miso), 32'd0);
        chk("underrun_count", 32'(urun_total), 32'(exp_urun));
    endtask

    initial begin
        rst = 1'b1; ss_n = 1'b1; sck = 1'b0; mosi = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00;
        clear_plan();
        repeat (3) @(negedge clk);
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_miso_oe", 32'(miso_oe), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_tx_underrun", 32'(tx_underrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (SYNC + 3) @(negedge clk);

        // Queued reply A5 against master byte 3C.
        tx_push(8'hA5);
        mo_bytes[0] = 8'h3C;
        rx_before = rxv_total;
        frame(8);
        chk("t1_rx_count", 32'(rxv_total - rx_before), 32'd1);
        chk("t1_tx_ready", 32'(tx_ready), 32'd1);

        // Nothing queued: idle byte with exactly one underrun.
        mo_bytes[0] = 8'h00;
        frame(8);
        chk("t2_rx_data", 32'(rx_data), 32'h00);

        // Two bytes under one select, second reply queued mid-frame.
        tx_push(8'h11);
        mo_bytes[0] = 8'h81;
        mo_bytes[1] = 8'h42;
        mid_valid[1] = 1'b1;
        mid_data[1]  = 8'h22;
        rx_before = rxv_total;
        frame(16);
        chk("t3_rx_count", 32'(rxv_total - rx_before), 32'd2);
        chk("t3_rx_hold", 32'(rx_data), 32'h42);
        clear_plan();

        // Deselect after five bits, then a clean frame.
        mo_bytes[0] = 8'hF0;
        rx_before = rxv_total;
        frame(5);
        chk("t4_no_rx", 32'(rxv_total - rx_before), 32'd0);
        chk("t4_rx_kept", 32'(rx_data), 32'h42);
        mo_bytes[0] = 8'h96;
        tx_push(8'h5C);
        frame(8);
        chk("t4_rx_count", 32'(rxv_total - rx_before), 32'd1);

        // Reset in the middle of a frame with the holding register full.
        tx_push(8'h5A);
        @(negedge clk);
        ss_n = 1'b0;
        repeat (PH) @(negedge clk);
        scratch = hold_q.pop_front();
        tx_push(8'hC3);
        mosi = 1'b1;
        sck  = 1'b1;
        repeat (PH) @(negedge clk);
        sck = 1'b0;
        repeat (PH) @(negedge clk);
        sck = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1; ss_n = 1'b1; sck = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_miso", 32'(miso), 32'd0);
        chk("mid_rst_miso_oe", 32'(miso_oe), 32'd0);
        chk("mid_rst_rx_data", 32'(rx_data), 32'd0);
        chk("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("mid_rst_tx_underrun", 32'(tx_underrun), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        hold_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (SYNC + 3) @(negedge clk);

        // Writes offered while full must not overwrite the queued byte.
        tx_push(8'hB7);
        for (int i = 0; i < 5; i++) tx_push(8'h48 + 8'(i));
        mo_bytes[0] = 8'h6E;
        frame(8);

        // Randomized frames of one to three bytes.
        for (int r = 0; r < 15; r++) begin
            int nb;
            nb = $urandom_range(1, 3);
            for (int k = 0; k < 8; k++) begin
                mo_bytes[k]  = 8'($urandom_range(0, 255));
                mid_valid[k] = 1'($urandom_range(0, 1));
                mid_data[k]  = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 1) == 1 && hold_q.size() == 0)
                tx_push(8'($urandom_range(0, 255)));
            rx_before = rxv_total;
            frame(nb * 8);
            chk("rand_rx_count", 32'(rxv_total - rx_before), 32'(nb));
            chk("rand_rx_hold", 32'(rx_data), 32'(mo_bytes[nb-1]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
